// File: rtl/controle_elevador.sv
// controle_elevador
//   Sequencing controller for a 3-floor elevator (terreo=0, primeiro=1, segundo=2).
//   Cabin and landing calls are merged into one pending vector. The current
//   direction is served to completion before turning around (SCAN). The block
//   drives the motor and the door and tracks the current floor.
//
// Parameters
//   TRAVEL_CYCLES  clocks to move one floor (>=1)
//   DOOR_CYCLES    clocks the door stays open per stop (>=1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active low
//   call_in     cabin calls, bit f = floor f, level sampled every cycle
//   call_out    landing calls, bit f = floor f, level sampled every cycle
//   andar       current floor code {A1,A0}: 00, 01, 10
//   motor_up    cabin moving up
//   motor_down  cabin moving down
//   door_open   door open at andar
//   pending     latched calls not yet served
module controle_elevador #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] call_in,
    input  logic [2:0] call_out,
    output logic [1:0] andar,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [2:0] pending
);

    localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] ONE         = TW'(1);

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic          dir, dir_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [1:0]    andar_nx;
    logic [2:0]    pending_nx;

    logic [2:0]    req;
    logic [3:0]    req_x;        // req padded so a 2-bit floor code always indexes in range
    logic          hit_here;
    logic          calls_above;
    logic          calls_below;
    logic [1:0]    floor_up;
    logic [1:0]    floor_dn;

    // Every decision this cycle sees the latched calls plus the live inputs,
    // so a call arriving on the timer==0 cycle still stops the cabin.
    assign req      = pending | call_in | call_out;
    assign req_x    = {1'b0, req};
    assign hit_here = req_x[andar];
    assign floor_up = andar + 2'd1;
    assign floor_dn = andar - 2'd1;

    assign calls_above = (andar == 2'd0) ? (req[1] | req[2]) :
                         (andar == 2'd1) ? req[2] : 1'b0;
    assign calls_below = (andar == 2'd2) ? (req[1] | req[0]) :
                         (andar == 2'd1) ? req[0] : 1'b0;

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        timer_nx = timer;
        andar_nx = andar;

        case (state)
            IDLE: begin
                if (hit_here) begin
                    state_nx = DOOR_OPEN;
                    timer_nx = DOOR_LOAD;
                end else if ((dir == DIR_UP) ? calls_above : calls_below) begin
                    state_nx = (dir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                    timer_nx = TRAVEL_LOAD;
                end else if ((dir == DIR_UP) ? calls_below : calls_above) begin
                    dir_nx   = ~dir;
                    state_nx = (dir == DIR_UP) ? MOVE_DOWN : MOVE_UP;
                    timer_nx = TRAVEL_LOAD;
                end
            end

            MOVE_UP: begin
                if (timer != '0) begin
                    timer_nx = timer - ONE;
                end else begin
                    andar_nx = floor_up;
                    if (floor_up == 2'd2) dir_nx = DIR_DOWN;
                    if (req_x[floor_up]) begin
                        state_nx = DOOR_OPEN;
                        timer_nx = DOOR_LOAD;
                    end else if (floor_up == 2'd1 && req[2]) begin
                        timer_nx = TRAVEL_LOAD;
                    end else begin
                        state_nx = IDLE;
                        timer_nx = '0;
                    end
                end
            end

            MOVE_DOWN: begin
                if (timer != '0) begin
                    timer_nx = timer - ONE;
                end else begin
                    andar_nx = floor_dn;
                    if (floor_dn == 2'd0) dir_nx = DIR_UP;
                    if (req_x[floor_dn]) begin
                        state_nx = DOOR_OPEN;
                        timer_nx = DOOR_LOAD;
                    end else if (floor_dn == 2'd1 && req[0]) begin
                        timer_nx = TRAVEL_LOAD;
                    end else begin
                        state_nx = IDLE;
                        timer_nx = '0;
                    end
                end
            end

            DOOR_OPEN: begin
                // A fresh call for this floor holds the door for a full period.
                if (hit_here) begin
                    timer_nx = DOOR_LOAD;
                end else if (timer == '0) begin
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - ONE;
                end
            end

            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase

        // Calls for the floor where the door is (or is about to be) open are absorbed.
        pending_nx = req;
        if (state_nx == DOOR_OPEN) pending_nx = req & ~(3'b001 << andar_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dir        <= DIR_UP;
            timer      <= '0;
            andar      <= 2'd0;
            pending    <= 3'b000;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
        end else begin
            state      <= state_nx;
            dir        <= dir_nx;
            timer      <= timer_nx;
            andar      <= andar_nx;
            pending    <= pending_nx;
            motor_up   <= (state_nx == MOVE_UP);
            motor_down <= (state_nx == MOVE_DOWN);
            door_open  <= (state_nx == DOOR_OPEN);
        end
    end

endmodule

// File: tb/tb_controle_elevador.sv
module tb_controle_elevador;

    logic       clk;
    logic       rst_n;
    logic [2:0] call_in;
    logic [2:0] call_out;
    logic [1:0] andar;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [2:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    controle_elevador #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call_in   (call_in),
        .call_out  (call_out),
        .andar     (andar),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .door_open (door_open),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge: one cycle later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all(input string tag);
        chk({tag, " motor_up"},   32'(motor_up),   0);
        chk({tag, " motor_down"}, 32'(motor_down), 0);
        chk({tag, " door_open"},  32'(door_open),  0);
    endtask

    initial begin
        rst_n    = 1'b0;
        call_in  = 3'b000;
        call_out = 3'b000;

        // 1: reset values, then no activity without calls
        #1;
        chk("rst andar", 32'(andar), 0);
        chk("rst pending", 32'(pending), 0);
        idle_all("rst");
        #22;
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("t1 andar c%0d", c), 32'(andar), 0);
            chk($sformatf("t1 pending c%0d", c), 32'(pending), 0);
            idle_all($sformatf("t1 c%0d", c));
        end

        // 2: current-floor call opens the door for 3 cycles
        call_in = 3'b001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) call_in = 3'b000;
            chk($sformatf("t2 door c%0d", c), 32'(door_open), 32'(c <= 3));
            chk($sformatf("t2 pending c%0d", c), 32'(pending), 0);
            chk($sformatf("t2 motor c%0d", c), 32'(motor_up | motor_down), 0);
        end

        // 3: landing call at floor 2 from floor 0
        call_out = 3'b100;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) call_out = 3'b000;
            chk($sformatf("t3 motor_up c%0d", c), 32'(motor_up), 32'(c >= 1 && c <= 8));
            chk($sformatf("t3 andar c%0d", c), 32'(andar), (c < 5) ? 0 : (c < 9) ? 1 : 2);
            chk($sformatf("t3 door c%0d", c), 32'(door_open), 32'(c >= 9 && c <= 11));
            chk($sformatf("t3 pend2 c%0d", c), 32'(pending[2]), 32'(c < 9));
        end

        // return to floor 0 (direction becomes UP on arrival)
        call_in = 3'b001;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) call_in = 3'b000;
            chk($sformatf("ret0 motor_down c%0d", c), 32'(motor_down), 32'(c <= 8));
        end
        chk("ret0 andar", 32'(andar), 0);

        // 5: call for floor 1 while travelling 0->2 stops the cabin there first
        call_out = 3'b100;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) call_out = 3'b000;
            chk($sformatf("t5 motor_up c%0d", c), 32'(motor_up),
                32'((c >= 1 && c <= 4) || (c >= 9 && c <= 12)));
            chk($sformatf("t5 door c%0d", c), 32'(door_open),
                32'((c >= 5 && c <= 7) || (c >= 13 && c <= 15)));
            chk($sformatf("t5 andar c%0d", c), 32'(andar), (c < 5) ? 0 : (c < 13) ? 1 : 2);
            if (c == 2) call_in = 3'b010;
            if (c == 3) call_in = 3'b000;
        end

        // back to floor 0, then up to floor 1 so the cabin sits at 1 with dir=UP
        call_in = 3'b001;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) call_in = 3'b000;
        end
        chk("ret0b andar", 32'(andar), 0);
        call_in = 3'b010;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) call_in = 3'b000;
        end
        chk("go1 andar", 32'(andar), 1);
        idle_all("go1");

        // 4: floor 1, dir UP, calls 101 -> floor 2 first, then down to floor 0
        call_in = 3'b101;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) call_in = 3'b000;
            chk($sformatf("t4 motor_up c%0d", c), 32'(motor_up), 32'(c <= 4));
            chk($sformatf("t4 motor_down c%0d", c), 32'(motor_down), 32'(c >= 9 && c <= 16));
            chk($sformatf("t4 door c%0d", c), 32'(door_open),
                32'((c >= 5 && c <= 7) || (c >= 17 && c <= 19)));
            chk($sformatf("t4 andar c%0d", c), 32'(andar),
                (c < 5) ? 1 : (c < 13) ? 2 : (c < 17) ? 1 : 0);
            if (c == 1)  chk("t4 pending c1",  32'(pending), 32'(3'b101));
            if (c == 5)  chk("t4 pending c5",  32'(pending), 32'(3'b001));
            if (c == 17) chk("t4 pending c17", 32'(pending), 0);
        end

        // simultaneous cabin + landing call on floor 1: one pending bit, one stop
        call_in  = 3'b010;
        call_out = 3'b010;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin
                call_in  = 3'b000;
                call_out = 3'b000;
                chk("sim pending c1", 32'(pending), 32'(3'b010));
            end
            chk($sformatf("sim door c%0d", c), 32'(door_open), 32'(c >= 5 && c <= 7));
            chk($sformatf("sim motor c%0d", c), 32'(motor_up), 32'(c <= 4));
        end
        chk("sim andar", 32'(andar), 1);
        chk("sim pending end", 32'(pending), 0);

        // 6: asynchronous reset in the middle of a move
        call_out = 3'b100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) call_out = 3'b000;
            chk($sformatf("t6 motor_up c%0d", c), 32'(motor_up), 1);
        end
        chk("t6 pending pre", 32'(pending), 32'(3'b100));
        rst_n = 1'b0;
        #1;
        chk("t6 andar", 32'(andar), 0);
        chk("t6 pending", 32'(pending), 0);
        idle_all("t6");
        #2;
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("t6 post andar c%0d", c), 32'(andar), 0);
            idle_all($sformatf("t6 post c%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
